// File: rtl/dds_pkg.sv
// Shared encodings and helpers for the DDS burst phase generator.
package dds_pkg;

    localparam logic [1:0] MODE_CW   = 2'd0;
    localparam logic [1:0] MODE_LFM  = 2'd1;
    localparam logic [1:0] MODE_PSK  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Adding half scale (2^(W-1)) modulo 2^W only toggles the address MSB.
    function automatic logic half_scale_msb(input logic msb, input logic flip);
        return msb ^ flip;
    endfunction

endpackage

// File: rtl/dds_phase_core.sv
// Phase/step accumulator: load restarts at phase 0 with a fresh step, advance
// adds the step to the phase and optionally the chirp increment to the step.
module dds_phase_core #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic               chirp_en,
    input  logic [PHASE_W-1:0] step_init,
    input  logic [PHASE_W-1:0] delta,
    output logic [ADDR_W-1:0]  addr
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            step_q  <= '0;
        end else if (load) begin
            phase_q <= '0;
            step_q  <= step_init;
        end else if (advance) begin
            phase_q <= phase_q + step_q;
            if (chirp_en) begin
                step_q <= step_q + delta;
            end
        end
    end

    assign addr = phase_q[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/dds_burst_phase_gen.sv
// Burst phase sequencer for the DDS chain: CW, LFM and PSK pulse trains with
// downstream stall, abort, start-parameter validation and a busy flag.
module dds_burst_phase_gen
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned TW       = 16,
    parameter int unsigned NW       = 5,
    parameter int unsigned CODE_LEN = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SIGN_START_GEN,
    input  logic                SIGN_ABORT,
    input  logic [1:0]          MODE,
    input  logic [PHASE_W-1:0]  PHASE_STEP,
    input  logic [PHASE_W-1:0]  DELTA_STEP,
    input  logic [TW-1:0]       T_IMPULSE,
    input  logic [TW-1:0]       T_PERIOD,
    input  logic [NW-1:0]       NUM_OF_IMP,
    input  logic [TW-1:0]       CHIP_LEN,
    input  logic [CODE_LEN-1:0] PSK_CODE,
    input  logic                OUT_REG_READY,
    output logic [ADDR_W-1:0]   ROM_ADDRESS,
    output logic                ADDR_VALID,
    output logic                SIGN_START_CALC,
    output logic                SIGN_STOP_CALC,
    output logic                BUSY,
    output logic                PARAM_ERR,
    output logic [NW-1:0]       IMP_INDEX
);

    localparam int unsigned CIW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    state_e state_q, state_d;

    // Burst parameters captured on accept
    logic [1:0]          mode_q;
    logic [PHASE_W-1:0]  phase_step_q;
    logic [PHASE_W-1:0]  delta_q;
    logic [TW-1:0]       t_imp_q;
    logic [TW-1:0]       gap_len_q;
    logic [TW-1:0]       chip_len_q;
    logic [NW-1:0]       num_q;
    logic [CODE_LEN-1:0] code_q;

    logic [TW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  chip_cnt_q, chip_cnt_d;
    logic [CIW-1:0] chip_idx_q, chip_idx_d;
    logic [NW-1:0]  imp_idx_q, imp_idx_d;
    logic           start_calc_q, start_calc_d;
    logic           stop_q, stop_d;
    logic           perr_q, perr_d;

    logic               params_ok;
    logic               start_req;
    logic               accept;
    logic               core_load;
    logic               core_adv;
    logic [PHASE_W-1:0] load_step;
    logic [ADDR_W-1:0]  core_addr;
    logic               code_bit;

    assign params_ok = (NUM_OF_IMP != '0) && (T_IMPULSE != '0) && (T_PERIOD > T_IMPULSE) &&
                       (MODE != MODE_RSVD) && ((MODE != MODE_PSK) || (CHIP_LEN != '0));

    // An abort in IDLE suppresses the start; a stall defers it.
    assign start_req = SIGN_START_GEN && !SIGN_ABORT && OUT_REG_READY;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chip_cnt_d   = chip_cnt_q;
        chip_idx_d   = chip_idx_q;
        imp_idx_d    = imp_idx_q;
        start_calc_d = start_calc_q;
        stop_d       = 1'b0;
        perr_d       = 1'b0;
        accept       = 1'b0;
        core_load    = 1'b0;
        core_adv     = 1'b0;
        load_step    = phase_step_q;

        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (params_ok) begin
                        accept       = 1'b1;
                        state_d      = PULSE;
                        cnt_d        = '0;
                        chip_cnt_d   = '0;
                        chip_idx_d   = '0;
                        imp_idx_d    = '0;
                        start_calc_d = 1'b1;
                        core_load    = 1'b1;
                        load_step    = PHASE_STEP;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (OUT_REG_READY) begin
                    start_calc_d = 1'b0;
                    core_adv     = 1'b1;
                    if (cnt_q == t_imp_q - TW'(1)) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                    if (chip_cnt_q == chip_len_q - TW'(1)) begin
                        chip_cnt_d = '0;
                        chip_idx_d = (chip_idx_q == CIW'(CODE_LEN - 1)) ? '0 :
                                     chip_idx_q + CIW'(1);
                    end else begin
                        chip_cnt_d = chip_cnt_q + TW'(1);
                    end
                end
            end
            GAP: begin
                if (OUT_REG_READY) begin
                    if (cnt_q == gap_len_q - TW'(1)) begin
                        cnt_d = '0;
                        if (imp_idx_q == num_q - NW'(1)) begin
                            state_d   = IDLE;
                            stop_d    = 1'b1;
                            imp_idx_d = '0;
                        end else begin
                            state_d    = PULSE;
                            imp_idx_d  = imp_idx_q + NW'(1);
                            chip_cnt_d = '0;
                            chip_idx_d = '0;
                            core_load  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides a stall and a coincident natural end (single STOP)
        if (SIGN_ABORT && (state_q != IDLE)) begin
            state_d      = IDLE;
            stop_d       = 1'b1;
            start_calc_d = 1'b0;
            cnt_d        = '0;
            imp_idx_d    = '0;
            core_load    = 1'b0;
            core_adv     = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            chip_cnt_q   <= '0;
            chip_idx_q   <= '0;
            imp_idx_q    <= '0;
            start_calc_q <= 1'b0;
            stop_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chip_cnt_q   <= chip_cnt_d;
            chip_idx_q   <= chip_idx_d;
            imp_idx_q    <= imp_idx_d;
            start_calc_q <= start_calc_d;
            stop_q       <= stop_d;
            perr_q       <= perr_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q       <= MODE_CW;
            phase_step_q <= '0;
            delta_q      <= '0;
            t_imp_q      <= '0;
            gap_len_q    <= '0;
            chip_len_q   <= '0;
            num_q        <= '0;
            code_q       <= '0;
        end else if (accept) begin
            mode_q       <= MODE;
            phase_step_q <= PHASE_STEP;
            delta_q      <= DELTA_STEP;
            t_imp_q      <= T_IMPULSE;
            gap_len_q    <= T_PERIOD - T_IMPULSE;
            chip_len_q   <= CHIP_LEN;
            num_q        <= NUM_OF_IMP;
            code_q       <= PSK_CODE;
        end
    end

    dds_phase_core #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W)
    ) u_phase_core (
        .clk       (CLK),
        .rst       (RESET),
        .load      (core_load),
        .advance   (core_adv),
        .chirp_en  (mode_q == MODE_LFM),
        .step_init (load_step),
        .delta     (delta_q),
        .addr      (core_addr)
    );

    assign code_bit = (mode_q == MODE_PSK) && code_q[chip_idx_q];

    assign ROM_ADDRESS     = (state_q == PULSE) ?
                             {half_scale_msb(core_addr[ADDR_W-1], code_bit), core_addr[ADDR_W-2:0]} :
                             '0;
    assign ADDR_VALID      = (state_q == PULSE);
    assign BUSY            = (state_q != IDLE);
    assign SIGN_START_CALC = start_calc_q;
    assign SIGN_STOP_CALC  = stop_q;
    assign PARAM_ERR       = perr_q;
    assign IMP_INDEX       = imp_idx_q;

endmodule

// File: tb/tb_dds_burst_phase_gen.sv
// Directed self-checking bench for dds_burst_phase_gen: CW, LFM, PSK, stall,
// back-to-back start, abort, parameter rejection and asynchronous reset.
module tb_dds_burst_phase_gen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SIGN_START_GEN;
    logic        SIGN_ABORT;
    logic [1:0]  MODE;
    logic [31:0] PHASE_STEP;
    logic [31:0] DELTA_STEP;
    logic [15:0] T_IMPULSE;
    logic [15:0] T_PERIOD;
    logic [4:0]  NUM_OF_IMP;
    logic [15:0] CHIP_LEN;
    logic [15:0] PSK_CODE;
    logic        OUT_REG_READY;
    logic [11:0] ROM_ADDRESS;
    logic        ADDR_VALID;
    logic        SIGN_START_CALC;
    logic        SIGN_STOP_CALC;
    logic        BUSY;
    logic        PARAM_ERR;
    logic [4:0]  IMP_INDEX;

    // {valid, busy, start_calc, stop_calc, param_err}
    logic [4:0]  flags;
    assign flags = {ADDR_VALID, BUSY, SIGN_START_CALC, SIGN_STOP_CALC, PARAM_ERR};

    int checks = 0;
    int errors = 0;

    dds_burst_phase_gen #(
        .PHASE_W  (32),
        .ADDR_W   (12),
        .TW       (16),
        .NW       (5),
        .CODE_LEN (16)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SIGN_START_GEN  (SIGN_START_GEN),
        .SIGN_ABORT      (SIGN_ABORT),
        .MODE            (MODE),
        .PHASE_STEP      (PHASE_STEP),
        .DELTA_STEP      (DELTA_STEP),
        .T_IMPULSE       (T_IMPULSE),
        .T_PERIOD        (T_PERIOD),
        .NUM_OF_IMP      (NUM_OF_IMP),
        .CHIP_LEN        (CHIP_LEN),
        .PSK_CODE        (PSK_CODE),
        .OUT_REG_READY   (OUT_REG_READY),
        .ROM_ADDRESS     (ROM_ADDRESS),
        .ADDR_VALID      (ADDR_VALID),
        .SIGN_START_CALC (SIGN_START_CALC),
        .SIGN_STOP_CALC  (SIGN_STOP_CALC),
        .BUSY            (BUSY),
        .PARAM_ERR       (PARAM_ERR),
        .IMP_INDEX       (IMP_INDEX)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        SIGN_START_GEN = 1'b0;
        SIGN_ABORT     = 1'b0;
        MODE           = 2'd0;
        PHASE_STEP     = '0;
        DELTA_STEP     = '0;
        T_IMPULSE      = '0;
        T_PERIOD       = '0;
        NUM_OF_IMP     = '0;
        CHIP_LEN       = '0;
        PSK_CODE       = '0;
        OUT_REG_READY  = 1'b1;
    endtask

    task automatic set_cw();
        MODE       = 2'd0;
        PHASE_STEP = 32'h0100_0000;
        T_IMPULSE  = 16'd4;
        T_PERIOD   = 16'd10;
        NUM_OF_IMP = 5'd2;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_inputs();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL reset flags: got %b expected 00000", flags);
        end
        checks++;
        if (ROM_ADDRESS !== 12'd0 || IMP_INDEX !== 5'd0) begin
            errors++;
            $display("FAIL reset addr/idx: got %0d/%0d expected 0/0", ROM_ADDRESS, IMP_INDEX);
        end
        RESET = 1'b0;
    endtask

    // Two-pulse CW burst, optionally with OUT_REG_READY low in cycles 2-3.
    task automatic test_cw(input bit stall);
        int e;
        logic [4:0]  ef;
        logic [11:0] ea;
        logic [4:0]  ei;
        bit p0, p1;
        set_cw();
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            e  = !stall ? c : (c <= 2) ? c : (c <= 4) ? 2 : c - 2;
            p0 = (e >= 1 && e <= 4);
            p1 = (e >= 11 && e <= 14);
            ea = p0 ? 12'(16 * (e - 1)) : p1 ? 12'(16 * (e - 11)) : 12'd0;
            ef = {p0 || p1, e >= 1 && e <= 20, c == 1, e == 21, 1'b0};
            ei = (e >= 11 && e <= 20) ? 5'd1 : 5'd0;
            checks++;
            if (flags !== ef) begin
                errors++;
                $display("FAIL %s flags c%0d: got %b expected %b", stall ? "stall" : "cw", c,
                         flags, ef);
            end
            checks++;
            if (ROM_ADDRESS !== ea) begin
                errors++;
                $display("FAIL %s addr c%0d: got %0d expected %0d", stall ? "stall" : "cw", c,
                         ROM_ADDRESS, ea);
            end
            if (e <= 20) begin
                checks++;
                if (IMP_INDEX !== ei) begin
                    errors++;
                    $display("FAIL %s imp_index c%0d: got %0d expected %0d",
                             stall ? "stall" : "cw", c, IMP_INDEX, ei);
                end
            end
            if (stall) OUT_REG_READY = !(c == 2 || c == 3);
        end
        idle_inputs();
    endtask

    // tab holds the five expected addresses, first sample in the low 12 bits.
    task automatic test_lfm(input logic [31:0] delta, input logic [59:0] tab);
        logic [11:0] ea;
        MODE           = 2'd1;
        PHASE_STEP     = '0;
        DELTA_STEP     = delta;
        T_IMPULSE      = 16'd5;
        T_PERIOD       = 16'd7;
        NUM_OF_IMP     = 5'd1;
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            ea = (c <= 5) ? tab[(c-1)*12 +: 12] : 12'd0;
            checks++;
            if (ADDR_VALID !== (c <= 5) || ROM_ADDRESS !== ea) begin
                errors++;
                $display("FAIL lfm %h c%0d: got valid %b addr %0d expected valid %b addr %0d",
                         delta, c, ADDR_VALID, ROM_ADDRESS, c <= 5, ea);
            end
            checks++;
            if (SIGN_STOP_CALC !== (c == 8)) begin
                errors++;
                $display("FAIL lfm stop c%0d: got %b expected %b", c, SIGN_STOP_CALC, c == 8);
            end
        end
        idle_inputs();
    endtask

    task automatic test_psk();
        logic [71:0] tab;
        logic [11:0] ea;
        int pos;
        bit v;
        tab = {12'd0, 12'd0, 12'd2048, 12'd2048, 12'd0, 12'd0};
        MODE           = 2'd2;
        PHASE_STEP     = '0;
        CHIP_LEN       = 16'd2;
        PSK_CODE       = 16'h0002;
        T_IMPULSE      = 16'd6;
        T_PERIOD       = 16'd8;
        NUM_OF_IMP     = 5'd2;
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            pos = (c <= 8) ? c - 1 : c - 9;
            v   = (c <= 14) && (pos < 6);
            ea  = v ? tab[pos*12 +: 12] : 12'd0;
            checks++;
            if (ADDR_VALID !== v || ROM_ADDRESS !== ea) begin
                errors++;
                $display("FAIL psk c%0d: got valid %b addr %0d expected valid %b addr %0d",
                         c, ADDR_VALID, ROM_ADDRESS, v, ea);
            end
            checks++;
            if (SIGN_STOP_CALC !== (c == 17) || BUSY !== (c <= 16)) begin
                errors++;
                $display("FAIL psk stop/busy c%0d: got %b/%b expected %b/%b", c,
                         SIGN_STOP_CALC, BUSY, c == 17, c <= 16);
            end
        end
        idle_inputs();
    endtask

    // Start held high across the end of a burst restarts on the first IDLE cycle.
    task automatic test_back_to_back();
        logic [44:0] ftab;
        logic [4:0]  ef;
        logic [11:0] ea;
        ftab = {5'b00000, 5'b00010, 5'b01000, 5'b11000, 5'b11100,
                5'b00010, 5'b01000, 5'b11000, 5'b11100};
        set_cw();
        T_IMPULSE      = 16'd2;
        T_PERIOD       = 16'd3;
        NUM_OF_IMP     = 5'd1;
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            ef = ftab[(c-1)*5 +: 5];
            ea = (c == 2 || c == 6) ? 12'd16 : 12'd0;
            checks++;
            if (flags !== ef || ROM_ADDRESS !== ea) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %b/%0d expected %b/%0d", c, flags,
                         ROM_ADDRESS, ef, ea);
            end
            if (c == 5) SIGN_START_GEN = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        logic [4:0]  ef;
        logic [11:0] ea;
        bit p0;
        // Abort during the second pulse
        set_cw();
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            if (c <= 12) begin
                p0 = (c >= 1 && c <= 4);
                ea = p0 ? 12'(16 * (c - 1)) : (c >= 11) ? 12'(16 * (c - 11)) : 12'd0;
                ef = {p0 || c >= 11, 1'b1, c == 1, 2'b00};
            end else begin
                ea = 12'd0;
                ef = (c == 13) ? 5'b00010 : 5'b00000;
            end
            checks++;
            if (flags !== ef || ROM_ADDRESS !== ea) begin
                errors++;
                $display("FAIL abort c%0d: got %b/%0d expected %b/%0d", c, flags, ROM_ADDRESS,
                         ef, ea);
            end
            SIGN_ABORT = (c == 12);
        end
        // Abort in IDLE blocks a valid start in the same cycle
        set_cw();
        SIGN_START_GEN = 1'b1;
        SIGN_ABORT     = 1'b1;
        tick();
        SIGN_START_GEN = 1'b0;
        SIGN_ABORT     = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (flags !== 5'b00000) begin
                errors++;
                $display("FAIL abort_idle c%0d: got %b expected 00000", c, flags);
            end
            tick();
        end
        // Abort coinciding with the natural end gives one STOP pulse
        T_IMPULSE      = 16'd2;
        T_PERIOD       = 16'd3;
        NUM_OF_IMP     = 5'd1;
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            SIGN_ABORT     = (c == 3);
            if (c >= 4) begin
                ef = (c == 4) ? 5'b00010 : 5'b00000;
                checks++;
                if (flags !== ef) begin
                    errors++;
                    $display("FAIL abort_end c%0d: got %b expected %b", c, flags, ef);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_param_err();
        for (int i = 0; i < 4; i++) begin
            set_cw();
            case (i)
                0: NUM_OF_IMP = 5'd0;
                1: T_PERIOD = 16'd4;
                2: MODE = 2'd3;
                default: begin MODE = 2'd2; CHIP_LEN = 16'd0; end
            endcase
            SIGN_START_GEN = 1'b1;
            tick();
            SIGN_START_GEN = 1'b0;
            checks++;
            if (flags !== 5'b00001) begin
                errors++;
                $display("FAIL param_err case%0d: got %b expected 00001", i, flags);
            end
            tick();
            checks++;
            if (flags !== 5'b00000) begin
                errors++;
                $display("FAIL param_err clear case%0d: got %b expected 00000", i, flags);
            end
        end
        // T_PERIOD = T_IMPULSE + 1 is the tightest legal gap
        set_cw();
        T_PERIOD       = 16'd5;
        NUM_OF_IMP     = 5'd1;
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            if (c == 1 || c == 5 || c == 6) begin
                checks++;
                if (flags !== ((c == 1) ? 5'b11100 : (c == 5) ? 5'b01000 : 5'b00010)) begin
                    errors++;
                    $display("FAIL min_gap c%0d: got %b", c, flags);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        set_cw();
        SIGN_START_GEN = 1'b1;
        tick();
        SIGN_START_GEN = 1'b0;
        tick();
        checks++;
        if (ADDR_VALID !== 1'b1 || ROM_ADDRESS !== 12'd16) begin
            errors++;
            $display("FAIL areset pre: got valid %b addr %0d expected 1/16", ADDR_VALID,
                     ROM_ADDRESS);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (flags !== 5'b00000 || ROM_ADDRESS !== 12'd0 || IMP_INDEX !== 5'd0) begin
            errors++;
            $display("FAIL areset immediate: got %b/%0d/%0d expected 00000/0/0", flags,
                     ROM_ADDRESS, IMP_INDEX);
        end
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL areset no_stop: got %b expected 00000", flags);
        end
        T_IMPULSE      = 16'd2;
        T_PERIOD       = 16'd3;
        NUM_OF_IMP     = 5'd1;
        SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            SIGN_START_GEN = 1'b0;
            checks++;
            if (flags !== ((c == 1) ? 5'b11100 : (c == 2) ? 5'b11000 :
                           (c == 3) ? 5'b01000 : 5'b00010) ||
                ROM_ADDRESS !== ((c == 2) ? 12'd16 : 12'd0)) begin
                errors++;
                $display("FAIL areset rerun c%0d: got %b/%0d", c, flags, ROM_ADDRESS);
            end
        end
        idle_inputs();
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_cw(1'b0);
        test_cw(1'b1);
        test_lfm(32'h0010_0000, {12'd6, 12'd3, 12'd1, 12'd0, 12'd0});
        test_lfm(32'hFFF0_0000, {12'd4090, 12'd4093, 12'd4095, 12'd0, 12'd0});
        test_psk();
        test_back_to_back();
        test_abort();
        test_param_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
